// File: rtl/udp_frame_packer.sv
// Frames an unstallable upstream byte stream into UDP payloads: 4-byte header, split at MAX_PAYLOAD.
// Optional XOR trailer byte when the PKT_CRC_EN macro is defined.
module udp_frame_packer #(
  parameter int          FIFO_DEPTH  = 2048,
  parameter int          MAX_PAYLOAD = 1024,
  parameter logic [7:0]  MAGIC       = 8'hAD
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  input  logic                          s_last,
  output logic [7:0]                    m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [15:0]                   seq_o,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);
  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [15:0]   MAX_CNT  = 16'(MAX_PAYLOAD);

`ifdef PKT_CRC_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2, TRL = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2} state_t;
`endif

  state_t        state_q, state_d;
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic [1:0]    hdr_idx_q, hdr_idx_d;
  logic [15:0]   pay_cnt_q, pay_cnt_d, pay_cnt_inc;
  logic [15:0]   seq_q, seq_d, drop_cnt_q, drop_cnt_d;
  logic          cont_q, cont_d, drop_pend_q, drop_pend_d;
  logic [7:0]    tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d, tlast_q, tlast_d;
`ifdef PKT_CRC_EN
  logic [7:0]    xor_q, xor_d;
`endif
  logic [8:0]    rd_word;
  logic          fifo_empty, fifo_full, wr_en, pop, drop, b1_load;
  logic          slot_free, frame_done, hit_max;

  assign fifo_empty  = (level_q == '0);
  assign fifo_full   = (level_q == LVL_FULL);
  assign rd_word     = mem_q[rd_ptr_q];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_en       = s_valid && (!fifo_full || pop);
  assign drop        = s_valid && !wr_en;
  assign slot_free   = !tvalid_q || m_tready;
  assign frame_done  = tvalid_q && m_tready && tlast_q;
  assign pay_cnt_inc = pay_cnt_q + 16'd1;
  assign hit_max     = (pay_cnt_inc == MAX_CNT);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {s_last, s_data};
  end

  always_comb begin
    level_d = level_q;
    if (wr_en && !pop)      level_d = level_q + LVL_ONE;
    else if (!wr_en && pop) level_d = level_q - LVL_ONE;
    drop_pend_d = (drop_pend_q && !b1_load) || drop;
    drop_cnt_d  = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_comb begin
    state_d   = state_q;
    hdr_idx_d = hdr_idx_q;
    pay_cnt_d = pay_cnt_q;
    cont_d    = cont_q;
    seq_d     = seq_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    pop       = 1'b0;
    b1_load   = 1'b0;
`ifdef PKT_CRC_EN
    xor_d     = xor_q;
`endif
    if (tvalid_q && m_tready) tvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d   = HDR;
          tvalid_d  = 1'b1;
          tdata_d   = MAGIC;
          tlast_d   = 1'b0;
          hdr_idx_d = 2'd1;
          pay_cnt_d = 16'd0;
`ifdef PKT_CRC_EN
          xor_d     = 8'h00;
`endif
        end
      end
      HDR: begin
        if (slot_free) begin
          tvalid_d  = 1'b1;
          tlast_d   = 1'b0;
          hdr_idx_d = hdr_idx_q + 2'd1;
          case (hdr_idx_q)
            2'd1: begin
              tdata_d = {6'b110000, cont_q, drop_pend_q};
              b1_load = 1'b1;
            end
            2'd2:    tdata_d = seq_q[15:8];
            default: tdata_d = seq_q[7:0];
          endcase
          if (hdr_idx_q == 2'd3) state_d = PAY;
        end
      end
      PAY: begin
        if (frame_done) begin
          state_d = IDLE;
          seq_d   = seq_q + 16'd1;
        end else if (slot_free && !fifo_empty) begin
          pop       = 1'b1;
          tvalid_d  = 1'b1;
          tdata_d   = rd_word[7:0];
          tlast_d   = 1'b0;
          pay_cnt_d = pay_cnt_inc;
`ifdef PKT_CRC_EN
          xor_d     = xor_q ^ rd_word[7:0];
`endif
          if (rd_word[8] || hit_max) begin
            // Ending on the count alone is a forced split; the next header flags it.
            cont_d = !rd_word[8];
`ifdef PKT_CRC_EN
            state_d = TRL;
`else
            tlast_d = 1'b1;
`endif
          end
        end
      end
`ifdef PKT_CRC_EN
      TRL: begin
        if (frame_done) begin
          state_d = IDLE;
          seq_d   = seq_q + 16'd1;
        end else if (slot_free && !tlast_q) begin
          tvalid_d = 1'b1;
          tdata_d  = xor_q;
          tlast_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      hdr_idx_q   <= 2'd0;
      pay_cnt_q   <= 16'd0;
      seq_q       <= 16'd0;
      drop_cnt_q  <= 16'd0;
      cont_q      <= 1'b0;
      drop_pend_q <= 1'b0;
      tdata_q     <= 8'h00;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
`ifdef PKT_CRC_EN
      xor_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q     <= level_d;
      hdr_idx_q   <= hdr_idx_d;
      pay_cnt_q   <= pay_cnt_d;
      seq_q       <= seq_d;
      drop_cnt_q  <= drop_cnt_d;
      cont_q      <= cont_d;
      drop_pend_q <= drop_pend_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
`ifdef PKT_CRC_EN
      xor_q       <= xor_d;
`endif
    end
  end

  assign m_tdata    = tdata_q;
  assign m_tvalid   = tvalid_q;
  assign m_tlast    = tlast_q;
  assign seq_o      = seq_q;
  assign drop_cnt   = drop_cnt_q;
  assign fifo_level = level_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_udp_frame_packer.sv
// Scoreboard bench for udp_frame_packer: dut_a splits at 4 bytes, dut_b at 1024; both use a 16-entry FIFO.
module tb_udp_frame_packer;
  localparam logic [7:0] MAGIC = 8'hAD;

  typedef struct packed { logic l; logic [7:0] d; } beat_t;
  typedef struct packed { logic [63:0] data; logic [3:0] len; logic toggle; logic [15:0] exp_seq; } vec_t;

  logic clk = 1'b0;
  always #4 clk = ~clk;
  logic rst_n;

  logic [7:0]  sa_data, sb_data, tdata_a, tdata_b;
  logic        sa_valid, sa_last, sb_valid, sb_last, ready_a, ready_b;
  logic        tvalid_a, tvalid_b, tlast_a, tlast_b, busy_a, busy_b;
  logic [15:0] seq_a, seq_b, drop_a, drop_b;
  logic [4:0]  level_a, level_b;

  udp_frame_packer #(.FIFO_DEPTH(16), .MAX_PAYLOAD(4), .MAGIC(MAGIC)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_data(sa_data), .s_valid(sa_valid), .s_last(sa_last),
    .m_tdata(tdata_a), .m_tvalid(tvalid_a), .m_tready(ready_a), .m_tlast(tlast_a),
    .seq_o(seq_a), .drop_cnt(drop_a), .fifo_level(level_a), .busy(busy_a));

  udp_frame_packer #(.FIFO_DEPTH(16), .MAX_PAYLOAD(1024), .MAGIC(MAGIC)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_data(sb_data), .s_valid(sb_valid), .s_last(sb_last),
    .m_tdata(tdata_b), .m_tvalid(tvalid_b), .m_tready(ready_b), .m_tlast(tlast_b),
    .seq_o(seq_b), .drop_cnt(drop_b), .fifo_level(level_b), .busy(busy_b));

  int          n_checks = 0;
  int          n_pass   = 0;
  beat_t       exp_a[$], exp_b[$], rec_q[$], drv_q[$];
  logic [15:0] seq_m [2];
  bit          cont_m [2];
  bit          stall_prev [2];
  logic [8:0]  prev_beat [2];
  bit          toggle_a = 1'b0;
  vec_t        vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic emit(input bit inst, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    if (inst) exp_b.push_back(b);
    else      exp_a.push_back(b);
  endtask

  // Reference framing: header, payload split at max_pay, optional XOR trailer.
  task automatic push_frames(input bit inst, input int max_pay, input bit drop_first);
    beat_t      bt;
    int         cnt = 0;
    logic [7:0] x = 8'h00;
    bit         need_hdr = 1'b1;
    bit         first = 1'b1;
    bit         fin;
    while (rec_q.size() > 0) begin
      bt = rec_q.pop_front();
      if (need_hdr) begin
        emit(inst, MAGIC, 1'b0);
        emit(inst, {6'b110000, cont_m[inst], first & drop_first}, 1'b0);
        emit(inst, seq_m[inst][15:8], 1'b0);
        emit(inst, seq_m[inst][7:0], 1'b0);
        need_hdr = 1'b0;
        first    = 1'b0;
        cnt      = 0;
        x        = 8'h00;
      end
      cnt++;
      x   = x ^ bt.d;
      fin = bt.l || (cnt == max_pay);
`ifdef PKT_CRC_EN
      emit(inst, bt.d, 1'b0);
      if (fin) emit(inst, x, 1'b1);
`else
      emit(inst, bt.d, fin);
`endif
      if (fin) begin
        cont_m[inst] = !bt.l;
        seq_m[inst]  = seq_m[inst] + 16'd1;
        need_hdr     = 1'b1;
      end
    end
  endtask

  task automatic add_beat(input logic [7:0] d, input logic l, input bit accepted);
    beat_t b;
    b.d = d;
    b.l = l;
    drv_q.push_back(b);
    if (accepted) rec_q.push_back(b);
  endtask

  task automatic drive_rec(input bit inst);
    beat_t b;
    while (drv_q.size() > 0) begin
      b = drv_q.pop_front();
      if (inst) begin sb_valid = 1'b1; sb_data = b.d; sb_last = b.l; end
      else      begin sa_valid = 1'b1; sa_data = b.d; sa_last = b.l; end
      tick();
    end
    sa_valid = 1'b0; sa_last = 1'b0;
    sb_valid = 1'b0; sb_last = 1'b0;
  endtask

  task automatic wait_drain(input bit inst, input int budget);
    int k = 0;
    while (k < budget && ((inst ? exp_b.size() : exp_a.size()) != 0 || (inst ? busy_b : busy_a))) begin
      tick();
      k++;
    end
    if (k >= budget) begin
      n_checks++;
      $display("FAIL drain inst %0d: %0d beats outstanding after %0d cycles, required 0",
               inst, inst ? exp_b.size() : exp_a.size(), budget);
      if (inst) exp_b.delete();
      else      exp_a.delete();
    end
  endtask

  task automatic mon(input bit inst, input logic v, input logic r, input logic [7:0] d, input logic l);
    beat_t e;
    if (stall_prev[inst]) chk(inst ? "stall_hold_b" : "stall_hold_a", {v, l, d}, {1'b1, prev_beat[inst]});
    if (v && r) begin
      if ((inst ? exp_b.size() : exp_a.size()) == 0) begin
        n_checks++;
        $display("FAIL beat_extra inst %0d: got 0x%0h, required no beat", inst, {l, d});
      end else begin
        e = inst ? exp_b.pop_front() : exp_a.pop_front();
        chk(inst ? "beat_b" : "beat_a", {l, d}, {e.l, e.d});
      end
    end
    stall_prev[inst] = v && !r;
    prev_beat[inst]  = {l, d};
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(1'b0, tvalid_a, ready_a, tdata_a, tlast_a);
      mon(1'b1, tvalid_b, ready_b, tdata_b, tlast_b);
    end else begin
      stall_prev[0] = 1'b0;
      stall_prev[1] = 1'b0;
    end
  end

  initial begin
    ready_a = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_a = toggle_a ? ~ready_a : 1'b1;
    end
  end

  initial begin
    vecs[0] = '{data: 64'h0000_0000_0033_2211, len: 4'd3, toggle: 1'b0, exp_seq: 16'd1};
    vecs[1] = '{data: 64'h0000_0605_0403_0201, len: 4'd6, toggle: 1'b0, exp_seq: 16'd3};
    vecs[2] = '{data: 64'h0000_00A4_A3A2_A1A0, len: 4'd5, toggle: 1'b1, exp_seq: 16'd5};
    vecs[3] = '{data: 64'h0000_0000_7E3C_C35A, len: 4'd4, toggle: 1'b1, exp_seq: 16'd6};
    vecs[4] = '{data: 64'h0000_0000_0033_F00F, len: 4'd3, toggle: 1'b0, exp_seq: 16'd7};
    vecs[5] = '{data: 64'h0000_0000_0000_00FF, len: 4'd1, toggle: 1'b0, exp_seq: 16'd8};
    seq_m[0] = 16'd0; seq_m[1] = 16'd0; cont_m[0] = 1'b0; cont_m[1] = 1'b0;
    sa_data = 8'h00; sa_valid = 1'b0; sa_last = 1'b0;
    sb_data = 8'h00; sb_valid = 1'b0; sb_last = 1'b0;
    ready_b = 1'b1;
    rst_n   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_tvalid", {31'd0, tvalid_a}, 32'd0);
    chk("rst_tlast",  {31'd0, tlast_a}, 32'd0);
    chk("rst_tdata",  {24'd0, tdata_a}, 32'd0);
    chk("rst_seq",    {16'd0, seq_a}, 32'd0);
    chk("rst_drop",   {16'd0, drop_a}, 32'd0);
    chk("rst_level",  {27'd0, level_a}, 32'd0);
    chk("rst_busy",   {31'd0, busy_a}, 32'd0);

    // Latency: byte written at cycle 0, header b0 at cycle 2, payload at cycle 6.
    rec_q.push_back('{l: 1'b1, d: 8'h5C});
    push_frames(1'b1, 1024, 1'b0);
    sb_valid = 1'b1; sb_data = 8'h5C; sb_last = 1'b1;
    tick();
    sb_valid = 1'b0; sb_last = 1'b0;
    chk("lat_cycle1_tvalid", {31'd0, tvalid_b}, 32'd0);
    tick();
    chk("lat_cycle2_b0", {23'd0, tvalid_b, tdata_b}, {23'd0, 1'b1, MAGIC});
    repeat (4) tick();
    chk("lat_cycle6_pay", {22'd0, tvalid_b, tlast_b, tdata_b}, {22'd0, 1'b1, 1'b1, 8'h5C});
    wait_drain(1'b1, 100);
    chk("lat_seq", {16'd0, seq_b}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < int'(vecs[i].len); j++)
        add_beat(vecs[i].data[8*j +: 8], j == int'(vecs[i].len) - 1, 1'b1);
      push_frames(1'b0, 4, 1'b0);
      toggle_a = vecs[i].toggle;
      drive_rec(1'b0);
      wait_drain(1'b0, 300);
      toggle_a = 1'b0;
      chk("vec_seq", {16'd0, seq_a}, {16'd0, vecs[i].exp_seq});
      $display("vec %0d: len %0d toggle %0d seq_o %0d (want %0d)", i, vecs[i].len, vecs[i].toggle,
               seq_a, vecs[i].exp_seq);
    end

    // Overflow: 20 bytes into 16 entries while stalled; the 4 late bytes are dropped.
    ready_b = 1'b0;
    for (int i = 1; i <= 20; i++) add_beat(8'h40 + 8'(i), (i == 8) || (i == 16), i <= 16);
    push_frames(1'b1, 1024, 1'b1);
    drive_rec(1'b1);
    tick();
    chk("ovf_drop_cnt", {16'd0, drop_b}, 32'd4);
    chk("ovf_level", {27'd0, level_b}, 32'd16);
    chk("ovf_b0_held", {23'd0, tvalid_b, tdata_b}, {23'd0, 1'b1, MAGIC});
    ready_b = 1'b1;
    wait_drain(1'b1, 200);
    chk("ovf_drop_after", {16'd0, drop_b}, 32'd4);
    chk("ovf_level_after", {27'd0, level_b}, 32'd0);
    $display("overflow: drop_cnt %0d seq_o %0d", drop_b, seq_b);

    // Sequence wrap.
    force dut_b.seq_q = 16'hFFFF;
    tick();
    release dut_b.seq_q;
    tick();
    chk("wrap_preload", {16'd0, seq_b}, 32'h0000_FFFF);
    seq_m[1] = 16'hFFFF;
    add_beat(8'h77, 1'b1, 1'b1);
    push_frames(1'b1, 1024, 1'b0);
    drive_rec(1'b1);
    wait_drain(1'b1, 100);
    chk("wrap_seq", {16'd0, seq_b}, 32'd0);
    $display("wrap: seq_o %0d", seq_b);

    // Asynchronous reset in the middle of a payload.
    for (int j = 0; j < 3; j++) add_beat(vecs[4].data[8*j +: 8], j == 2, 1'b1);
    push_frames(1'b0, 4, 1'b0);
    drive_rec(1'b0);
    repeat (3) tick();
    chk("midframe_busy", {31'd0, busy_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", {31'd0, tvalid_a}, 32'd0);
    chk("arst_tlast",  {31'd0, tlast_a}, 32'd0);
    chk("arst_tdata",  {24'd0, tdata_a}, 32'd0);
    chk("arst_seq",    {16'd0, seq_a}, 32'd0);
    chk("arst_level",  {27'd0, level_a}, 32'd0);
    chk("arst_busy",   {31'd0, busy_a}, 32'd0);
    exp_a.delete();
    exp_b.delete();
    seq_m[0] = 16'd0; seq_m[1] = 16'd0; cont_m[0] = 1'b0; cont_m[1] = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", {30'd0, tvalid_a, busy_a}, 32'd0);
    add_beat(8'h3A, 1'b1, 1'b1);
    push_frames(1'b0, 4, 1'b0);
    drive_rec(1'b0);
    wait_drain(1'b0, 100);
    chk("post_rst_seq", {16'd0, seq_a}, 32'd1);
    $display("reset: post-reset frame seq_o %0d", seq_a);

    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
